// File: rtl/logic_seq_pkg.sv
// rtl/logic_seq_pkg.sv - shared opcodes, FSM state encoding and data width for logic_seq
package logic_seq_pkg;

    localparam int DATA_W = 8;

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_XOR   = 3'b001;
    localparam logic [2:0] OP_NAND  = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_NOT_A = 3'b100;
    localparam logic [2:0] OP_NOT_B = 3'b101;
    localparam logic [2:0] OP_NOR   = 3'b110;
    localparam logic [2:0] OP_XNOR  = 3'b111;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t EXEC = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/logic_seq_bitwise.sv
// rtl/logic_seq_bitwise.sv - 8-bit bitwise logic unit, purely combinational
module bitwise
    import logic_seq_pkg::*;
(
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] y_o
);

    always_comb begin
        y_o = '0;
        case (op_i)
            OP_AND:   y_o = a_i & b_i;
            OP_XOR:   y_o = a_i ^ b_i;
            OP_NAND:  y_o = ~(a_i & b_i);
            OP_OR:    y_o = a_i | b_i;
            OP_NOT_A: y_o = ~a_i;
            OP_NOT_B: y_o = ~b_i;
            OP_NOR:   y_o = ~(a_i | b_i);
            OP_XNOR:  y_o = ~(a_i ^ b_i);
            default:  y_o = '0;
        endcase
    end

endmodule

// File: rtl/logic_seq.sv
// rtl/logic_seq.sv - command/result sequencer around the bitwise unit; LOGIC_SEQ_CHAIN_EN adds cmd_chain and an accumulator
module logic_seq
    import logic_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
`ifdef LOGIC_SEQ_CHAIN_EN
    input  logic              cmd_chain,
`endif
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,
    output logic              res_parity,
    output logic [2:0]        res_op,
    output logic [15:0]       ops_done
);

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic              res_zero_q, res_zero_d;
    logic              res_parity_q, res_parity_d;
    logic [2:0]        res_op_q, res_op_d;
    logic [15:0]       ops_done_q, ops_done_d;
    logic [DATA_W-1:0] alu_y;
    logic [DATA_W-1:0] a_sel;

`ifdef LOGIC_SEQ_CHAIN_EN
    logic [DATA_W-1:0] acc_q, acc_d;
    assign a_sel = cmd_chain ? acc_q : cmd_a;
`else
    assign a_sel = cmd_a;
`endif

    bitwise u_bitwise (
        .op_i (op_q),
        .a_i  (a_q),
        .b_i  (b_q),
        .y_o  (alu_y)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        res_data_d   = res_data_q;
        res_zero_d   = res_zero_q;
        res_parity_d = res_parity_q;
        res_op_d     = res_op_q;
        ops_done_d   = ops_done_q;
`ifdef LOGIC_SEQ_CHAIN_EN
        acc_d        = acc_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    a_d     = a_sel;
                    b_d     = cmd_b;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_data_d   = alu_y;
                res_zero_d   = ~|alu_y;
                res_parity_d = ^alu_y;
                res_op_d     = op_q;
`ifdef LOGIC_SEQ_CHAIN_EN
                acc_d        = alu_y;
`endif
                state_d      = DONE;
            end
            DONE: begin
                // Counter wraps naturally; no saturation.
                if (res_ready) begin
                    ops_done_d = ops_done_q + 16'd1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            res_data_q   <= '0;
            res_zero_q   <= 1'b1;
            res_parity_q <= 1'b0;
            res_op_q     <= '0;
            ops_done_q   <= '0;
`ifdef LOGIC_SEQ_CHAIN_EN
            acc_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_data_q   <= res_data_d;
            res_zero_q   <= res_zero_d;
            res_parity_q <= res_parity_d;
            res_op_q     <= res_op_d;
            ops_done_q   <= ops_done_d;
`ifdef LOGIC_SEQ_CHAIN_EN
            acc_q        <= acc_d;
`endif
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign res_valid  = (state_q == DONE);
    assign res_data   = res_data_q;
    assign res_zero   = res_zero_q;
    assign res_parity = res_parity_q;
    assign res_op     = res_op_q;
    assign ops_done   = ops_done_q;

endmodule

// File: tb/tb_logic_seq.sv
// tb/tb_logic_seq.sv - self-checking bench for logic_seq (chain checks when LOGIC_SEQ_CHAIN_EN is defined)
module tb_logic_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [7:0]  cmd_a = '0;
    logic [7:0]  cmd_b = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [7:0]  res_data;
    logic        res_zero;
    logic        res_parity;
    logic [2:0]  res_op;
    logic [15:0] ops_done;
`ifdef LOGIC_SEQ_CHAIN_EN
    logic        cmd_chain = 1'b0;
`endif

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       zero;
        logic       parity;
        logic [2:0] op;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_fail = 0;
    logic [15:0] ops_exp = '0;

    logic_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
`ifdef LOGIC_SEQ_CHAIN_EN
        .cmd_chain  (cmd_chain),
`endif
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_zero   (res_zero),
        .res_parity (res_parity),
        .res_op     (res_op),
        .ops_done   (ops_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one command through; hold = cycles of res_ready low in DONE with a competing command offered.
    task automatic do_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp, input logic chain, input int hold);
        exp_t e;
        int   lat;
        @(negedge clk);
        chk("cmd_ready_idle", {15'd0, cmd_ready}, 16'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
`ifdef LOGIC_SEQ_CHAIN_EN
        cmd_chain = chain;
`else
        if (chain) $display("chain request ignored in this build");
`endif
        e.data = exp; e.zero = (exp == 8'h00); e.parity = ^exp; e.op = op;
        sb.push_back(e);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_a     = 8'($urandom);
        cmd_b     = 8'($urandom);
`ifdef LOGIC_SEQ_CHAIN_EN
        cmd_chain = 1'b0;
`endif
        lat = 0;
        while (!res_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 16'(lat), 16'd2);
        e = sb.pop_front();
        chk("res_data", {8'd0, res_data}, {8'd0, e.data});
        chk("res_zero", {15'd0, res_zero}, {15'd0, e.zero});
        chk("res_parity", {15'd0, res_parity}, {15'd0, e.parity});
        chk("res_op", {13'd0, res_op}, {13'd0, e.op});
        for (int h = 0; h < hold; h++) begin
            cmd_valid = 1'b1;
            cmd_op    = 3'($urandom);
            cmd_a     = 8'($urandom);
            cmd_b     = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", {15'd0, res_valid}, 16'd1);
            chk("hold_cmd_ready", {15'd0, cmd_ready}, 16'd0);
            chk("hold_data", {8'd0, res_data}, {8'd0, e.data});
            chk("hold_op", {13'd0, res_op}, {13'd0, e.op});
            chk("hold_ops_done", ops_done, ops_exp);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        ops_exp++;
        @(negedge clk);
        chk("ops_done", ops_done, ops_exp);
        chk("valid_after_hs", {15'd0, res_valid}, 16'd0);
        chk("ready_after_hs", {15'd0, cmd_ready}, 16'd1);
        chk("data_retained", {8'd0, res_data}, {8'd0, e.data});
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 3'b001;
        cmd_a     = 8'h5A;
        cmd_b     = 8'hC3;
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        ops_exp   = '0;
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{3'b000, 8'hA5, 8'h0F, 8'h05};
        vecs[1] = '{3'b001, 8'hA5, 8'h0F, 8'hAA};
        vecs[2] = '{3'b010, 8'hA5, 8'h0F, 8'hFA};
        vecs[3] = '{3'b011, 8'hA5, 8'h0F, 8'hAF};
        vecs[4] = '{3'b100, 8'hA5, 8'h0F, 8'h5A};
        vecs[5] = '{3'b101, 8'hA5, 8'h0F, 8'hF0};
        vecs[6] = '{3'b110, 8'hA5, 8'h0F, 8'h50};
        vecs[7] = '{3'b111, 8'hA5, 8'h0F, 8'h55};

        apply_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_cmd_ready", {15'd0, cmd_ready}, 16'd1);
            chk("rst_res_valid", {15'd0, res_valid}, 16'd0);
        end
        chk("rst_res_data", {8'd0, res_data}, 16'h0000);
        chk("rst_res_zero", {15'd0, res_zero}, 16'd1);
        chk("rst_res_parity", {15'd0, res_parity}, 16'd0);
        chk("rst_res_op", {13'd0, res_op}, 16'd0);
        chk("rst_ops_done", ops_done, 16'h0000);

        do_cmd(3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0, 0);
        do_cmd(3'b101, 8'h00, 8'hFF, 8'h00, 1'b0, 0);

        for (int i = 0; i < 8; i++)
            do_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, 0);

        do_cmd(3'b011, 8'h12, 8'h40, 8'h52, 1'b0, 10);

        @(negedge clk);
        res_ready = 1'b1;
        repeat (3) @(negedge clk);
        res_ready = 1'b0;
        chk("idle_res_ready_ignored", ops_done, ops_exp);
        chk("idle_res_valid", {15'd0, res_valid}, 16'd0);

        @(negedge clk);
        force dut.ops_done_q = 16'hFFFF;
        @(negedge clk);
        release dut.ops_done_q;
        ops_exp = 16'hFFFF;
        @(negedge clk);
        chk("preload_ops_done", ops_done, 16'hFFFF);
        do_cmd(3'b110, 8'h01, 8'h02, 8'hFC, 1'b0, 0);
        chk("ops_done_wrap", ops_done, 16'h0000);

        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'b000; cmd_a = 8'hFF; cmd_b = 8'hFF;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("exec_entered", {15'd0, cmd_ready}, 16'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ops_exp = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_res_valid", {15'd0, res_valid}, 16'd0);
            chk("abort_cmd_ready", {15'd0, cmd_ready}, 16'd1);
        end
        chk("abort_ops_done", ops_done, 16'h0000);
        chk("abort_res_data", {8'd0, res_data}, 16'h0000);

`ifdef LOGIC_SEQ_CHAIN_EN
        do_cmd(3'b001, 8'h0F, 8'hFF, 8'hF0, 1'b0, 0);
        do_cmd(3'b000, 8'h77, 8'h3C, 8'h30, 1'b1, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
